// File: rtl/i2c_bit_engine.sv
// I2C write-byte bit engine: turns a quarter-bit tick into SCL/SDA waveforms
// for START / 8 data bits / ACK / STOP, one byte per accepted command.
module i2c_bit_engine #(
  parameter int SDA_SYNC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_start,
  input  logic       cmd_stop,
  input  logic [7:0] cmd_data,
  output logic       done,
  output logic       nack,
  output logic       busy,
  output logic       scl,
  output logic       sda_o,
  input  logic       sda_i
);

  typedef enum logic [2:0] {IDLE, START, DATA, ACK, STOP, HOLD} state_t;

  state_t              state, state_n;
  logic [1:0]          q, q_n;
  logic [2:0]          b, b_n;
  logic                hold, hold_n;
  logic [7:0]          data_l, data_n;
  logic                stop_l;
  logic                accept;
  logic                done_n;
  logic                run_tick;
  logic [SDA_SYNC-1:0] sda_sync;
  logic                sda_s;

  // Bus levels {scl, sda_o} for a given slot and quarter.
  function automatic logic [1:0] bus_levels(state_t st, logic [1:0] qq, logic [2:0] bb,
                                            logic [7:0] d, logic h);
    logic scl_mid;
    scl_mid = (qq == 2'd1) || (qq == 2'd2);
    bus_levels = 2'b11;
    case (st)
      START: begin
        case (qq)
          2'd0:    bus_levels = {~h, 1'b1};  // repeated START keeps SCL low first
          2'd1:    bus_levels = 2'b11;
          2'd2:    bus_levels = 2'b10;       // SDA falls with SCL high
          default: bus_levels = 2'b00;
        endcase
      end
      DATA:    bus_levels = {scl_mid, d[bb]};
      ACK:     bus_levels = {scl_mid, 1'b1};
      STOP: begin
        case (qq)
          2'd0:    bus_levels = 2'b00;
          2'd1:    bus_levels = 2'b10;
          default: bus_levels = 2'b11;       // SDA rises with SCL high
        endcase
      end
      HOLD:    bus_levels = 2'b01;
      default: bus_levels = 2'b11;
    endcase
  endfunction

  assign cmd_ready = (state == IDLE) || (state == HOLD);
  assign busy      = (state != IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign run_tick  = tick && !cmd_ready;
  assign sda_s     = sda_sync[SDA_SYNC-1];

  // Next-state: command accept, quarter advance and slot sequencing.
  always_comb begin
    state_n = state;
    q_n     = q;
    b_n     = b;
    hold_n  = hold;
    data_n  = data_l;
    done_n  = 1'b0;
    if (accept) begin
      q_n    = 2'd0;
      data_n = cmd_data;
      b_n    = 3'd7;
      if (cmd_start) begin
        state_n = START;
        hold_n  = (state == HOLD);
      end else begin
        state_n = DATA;
      end
    end else if (run_tick) begin
      q_n = q + 2'd1;
      if (q == 2'd3) begin
        case (state)
          START: begin
            state_n = DATA;
            b_n     = 3'd7;
          end
          DATA: begin
            if (b == 3'd0) state_n = ACK;
            else           b_n     = b - 3'd1;
          end
          ACK: begin
            if (stop_l) begin
              state_n = STOP;
            end else begin
              state_n = HOLD;
              done_n  = 1'b1;
            end
          end
          STOP: begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
          default: state_n = state;
        endcase
      end
    end
  end

  // Control state, registered bus levels, ACK capture and sda_i synchroniser.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      q        <= 2'd0;
      b        <= 3'd7;
      hold     <= 1'b0;
      scl      <= 1'b1;
      sda_o    <= 1'b1;
      done     <= 1'b0;
      nack     <= 1'b0;
      sda_sync <= '1;
    end else begin
      state        <= state_n;
      q            <= q_n;
      b            <= b_n;
      hold         <= hold_n;
      {scl, sda_o} <= bus_levels(state_n, q_n, b_n, data_n, hold_n);
      done         <= done_n;
      sda_sync[0]  <= sda_i;
      for (int i = 1; i < SDA_SYNC; i++) sda_sync[i] <= sda_sync[i-1];
      if (run_tick && (state == ACK) && (q == 2'd2)) nack <= sda_s;
    end
  end

  // Command payload, captured on accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      data_l <= cmd_data;
      stop_l <= cmd_stop;
    end
  end

endmodule

// File: tb/tb_i2c_bit_engine.sv
// Randomised bench for i2c_bit_engine: a quarter-by-quarter waveform model
// built from the bus protocol plus byte reconstruction from SCL rising edges.
module tb_i2c_bit_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_start = 1'b0;
  logic       cmd_stop = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       done, nack, busy, scl, sda_o;
  logic       sda_i = 1'b1;

  int errors = 0;
  int checks = 0;

  logic       held = 1'b0;      // bus owned with SCL low after a no-STOP command
  logic       slave_pull = 1'b0;
  logic       prev_scl = 1'b1;
  logic [1:0] exp_q[$];
  logic       rise_q[$];

  i2c_bit_engine #(.SDA_SYNC(2)) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_data(cmd_data),
    .done(done), .nack(nack), .busy(busy),
    .scl(scl), .sda_o(sda_o), .sda_i(sda_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_sda();
    sda_i = slave_pull ? 1'b0 : sda_o;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (!prev_scl && scl) rise_q.push_back(sda_o);
    prev_scl = scl;
    drive_sda();
  endtask

  // Expected {scl, sda} for every quarter of one command, from the bus rules.
  task automatic build_wave(input logic st, input logic [7:0] data, input logic from_hold,
                            input logic sp);
    exp_q.delete();
    if (st) begin
      exp_q.push_back({!from_hold, 1'b1});
      exp_q.push_back(2'b11);
      exp_q.push_back(2'b10);
      exp_q.push_back(2'b00);
    end
    for (int i = 7; i >= 0; i--) begin
      exp_q.push_back({1'b0, data[i]});
      exp_q.push_back({1'b1, data[i]});
      exp_q.push_back({1'b1, data[i]});
      exp_q.push_back({1'b0, data[i]});
    end
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b11);
    exp_q.push_back(2'b11);
    exp_q.push_back(2'b01);
    if (sp) begin
      exp_q.push_back(2'b00);
      exp_q.push_back(2'b10);
      exp_q.push_back(2'b11);
      exp_q.push_back(2'b11);
    end
  endtask

  // One command from accept to done. gap<0 picks random tick spacing.
  // stall_at/abort_at/inject_at are quarter indices, or -1 for none.
  task automatic run_cmd(input logic [7:0] data, input logic st, input logic sp,
                         input logic ack, input int gap, input int stall_at,
                         input int abort_at, input int inject_at,
                         input logic [7:0] inj_data, input logic inj_st, input logic inj_sp);
    int         n, ack_base, g, off, nrise;
    logic       from_hold;
    logic [7:0] rx;
    from_hold = held;
    build_wave(st, data, from_hold, sp);
    n        = exp_q.size();
    ack_base = (st ? 4 : 0) + 32;
    rise_q.delete();
    prev_scl = scl;
    check("ready_before_accept", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_data  = data;
    cmd_start = st;
    cmd_stop  = sp;
    tick      = 1'b0;
    step();
    cmd_valid = 1'b0;
    cmd_data  = ~data;
    cmd_start = $urandom_range(0, 1);
    cmd_stop  = $urandom_range(0, 1);
    check("accept_busy", busy, 1);
    check("accept_ready", cmd_ready, 0);
    check("accept_done", done, 0);
    check("quarter0", {scl, sda_o}, exp_q[0]);
    for (int k = 0; k < n; k++) begin
      if (k == inject_at) begin
        cmd_valid = 1'b1;
        cmd_data  = inj_data;
        cmd_start = inj_st;
        cmd_stop  = inj_sp;
      end
      g = (k == stall_at) ? 50 : ((gap < 0) ? int'($urandom_range(0, 3)) : gap);
      for (int c = 0; c < g; c++) begin
        step();
        check("stall_levels", {scl, sda_o}, exp_q[k]);
        check("stall_done", done, 0);
        if (cmd_valid) check("busy_ready", cmd_ready, 0);
      end
      if (k == abort_at) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_scl", scl, 1);
        check("abort_sda", sda_o, 1);
        check("abort_busy", busy, 0);
        check("abort_ready", cmd_ready, 1);
        check("abort_done", done, 0);
        check("abort_nack", nack, 0);
        held = 1'b0;
        slave_pull = 1'b0;
        drive_sda();
        return;
      end
      tick = 1'b1;
      step();
      tick = 1'b0;
      if (k + 1 == ack_base) begin
        slave_pull = ack;
        drive_sda();
      end
      if (k == ack_base + 3) begin
        slave_pull = 1'b0;
        drive_sda();
      end
      if (k < n - 1) begin
        check("quarter_levels", {scl, sda_o}, exp_q[k+1]);
        check("done_early", done, 0);
        if (cmd_valid) check("busy_ready", cmd_ready, 0);
      end else begin
        check("done_pulse", done, 1);
        check("nack_value", nack, !ack);
        check("end_levels", {scl, sda_o}, sp ? 2'b11 : 2'b01);
        check("end_ready", cmd_ready, 1);
        check("end_busy", busy, !sp);
      end
    end
    off   = (st && from_hold) ? 1 : 0;
    nrise = 9 + off + (sp ? 1 : 0);
    check("scl_rises", rise_q.size(), nrise);
    if (rise_q.size() == nrise) begin
      for (int i = 0; i < 8; i++) rx[7-i] = rise_q[off+i];
      check("rx_byte", rx, data);
      check("ack_released", rise_q[off+8], 1);
    end
    held = !sp;
  endtask

  initial begin
    logic [7:0] d;
    logic       st, sp, ak;
    int         stall;

    step();
    step();
    check("reset_scl", scl, 1);
    check("reset_sda", sda_o, 1);
    check("reset_busy", busy, 0);
    check("reset_ready", cmd_ready, 1);
    check("reset_done", done, 0);
    check("reset_nack", nack, 0);
    rst = 1'b0;
    step();

    // Full command with ACK, tick every 4 clk.
    run_cmd(8'hA5, 1'b1, 1'b1, 1'b1, 3, -1, -1, -1, 8'h00, 1'b0, 1'b0);
    step();
    check("after_done_low", done, 0);
    check("after_idle_ready", cmd_ready, 1);
    // Same byte, slave never acknowledges: STOP still issued.
    run_cmd(8'hA5, 1'b1, 1'b1, 1'b0, 3, -1, -1, -1, 8'h00, 1'b0, 1'b0);
    step();
    check("nack_held", nack, 1);
    // Reset during DATA bit 3 (quarter 1), then a normal command.
    run_cmd(8'h3C, 1'b1, 1'b1, 1'b1, 1, -1, 21, -1, 8'h00, 1'b0, 1'b0);
    step();
    run_cmd(8'hC3, 1'b1, 1'b1, 1'b1, 2, -1, -1, -1, 8'h00, 1'b0, 1'b0);
    // Back-to-back with repeated START through HOLD.
    run_cmd(8'h78, 1'b1, 1'b0, 1'b1, 3, -1, -1, -1, 8'h00, 1'b0, 1'b0);
    run_cmd(8'h00, 1'b1, 1'b1, 1'b1, 3, -1, -1, -1, 8'h00, 1'b0, 1'b0);
    // Tick stall of 50 clk during DATA bit 7 quarter 1.
    run_cmd(8'h96, 1'b1, 1'b1, 1'b1, 0, 5, -1, -1, 8'h00, 1'b0, 1'b0);
    // New command presented mid-transfer; taken only in the done cycle.
    run_cmd(8'h5A, 1'b1, 1'b1, 1'b1, 1, -1, -1, 10, 8'hE1, 1'b1, 1'b1);
    run_cmd(8'hE1, 1'b1, 1'b1, 1'b1, 1, -1, -1, -1, 8'h00, 1'b0, 1'b0);

    // Randomised command stream.
    for (int r = 0; r < 24; r++) begin
      d     = 8'($urandom);
      st    = held ? 1'($urandom_range(0, 1)) : 1'b1;
      sp    = 1'($urandom_range(0, 1));
      ak    = 1'($urandom_range(0, 1));
      stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 35)) : -1;
      run_cmd(d, st, sp, ak, -1, stall, -1, -1, 8'h00, 1'b0, 1'b0);
      if ($urandom_range(0, 1) == 1) step();
    end
    if (held) run_cmd(8'hFF, 1'b1, 1'b1, 1'b0, 0, -1, -1, -1, 8'h00, 1'b0, 1'b0);
    step();
    check("final_levels", {scl, sda_o}, 2'b11);
    check("final_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
